// File: rtl/c1_dtack_gen_pkg.sv
// Shared C1 bus-cycle definitions: FSM state encoding and PORT wait-strap encoding.
// Reused by the DTACK generator and by C1 register/debug logic.
package c1_dtack_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] PWAIT_0 = 2'd0;
  localparam logic [1:0] PWAIT_1 = 2'd1;
  localparam logic [1:0] PWAIT_2 = 2'd2;
  localparam logic [1:0] PWAIT_3 = 2'd3;

  // Cart straps are active low; the wait count is the inverted pair, nPWAIT1 as MSB.
  function automatic logic [1:0] port_waits(input logic npwait1, input logic npwait0);
    return {~npwait1, ~npwait0};
  endfunction

endpackage

// File: rtl/c1_dtack_gen_if.sv
// 68k-side bus-cycle signals between the CPU/decode side (master) and the DTACK generator (slave).
interface c1_dtack_gen_if;
  logic nAS;
  logic nROM_ZONE;
  logic nPORT_ZONE;
  logic nCARD_ZONE;
  logic nROMWAIT;
  logic nPWAIT0;
  logic nPWAIT1;
  logic PDTACK;
  logic nDTACK;
  logic BUSY;

  modport master (
    output nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
    input  nDTACK, BUSY
  );

  modport slave (
    input  nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
    output nDTACK, BUSY
  );
endinterface

// File: rtl/c1_dtack_gen_wait_sel.sv
// Combinational zone + strap to wait-count priority mux (ROM > PORT > CARD > other).
// Purely combinational; the caller samples the result only on the bus-cycle start edge.
module c1_wait_sel
  import c1_dtack_gen_pkg::*;
#(
  parameter int CNT_W      = 3,
  parameter int CARD_WAITS = 2,
  parameter int ROM_WAITS  = 1
) (
  input  logic             nROM_ZONE,
  input  logic             nPORT_ZONE,
  input  logic             nCARD_ZONE,
  input  logic             nROMWAIT,
  input  logic             nPWAIT0,
  input  logic             nPWAIT1,
  input  logic             PDTACK,
  output logic [CNT_W-1:0] waits
);

  always_comb begin
    waits = '0;
    if (!nROM_ZONE) begin
      waits = nROMWAIT ? '0 : CNT_W'(ROM_WAITS);
    end else if (!nPORT_ZONE) begin
      waits = PDTACK ? '0 : CNT_W'(port_waits(nPWAIT1, nPWAIT0));
    end else if (!nCARD_ZONE) begin
      waits = CNT_W'(CARD_WAITS);
    end
  end

endmodule

// File: rtl/c1_dtack_gen.sv
// 68k bus-cycle terminator: per-zone wait insertion, nDTACK low W edges after the nAS start edge.
// Optional macro C1_WAIT_STATS_EN adds the saturating WAIT_TOTAL cycle counter.
module c1_dtack_gen
  import c1_dtack_gen_pkg::*;
#(
  parameter int CARD_WAITS = 2,
  parameter int ROM_WAITS  = 1,
  parameter int CNT_W      = 3
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  c1_dtack_gen_if.slave     bus
`ifdef C1_WAIT_STATS_EN
  ,
  output logic [15:0]       WAIT_TOTAL
`endif
);

  if (CNT_W < 2 || CARD_WAITS >= (1 << CNT_W) || ROM_WAITS >= (1 << CNT_W)) begin : g_bad_cfg
    $error("c1_dtack_gen: wait values must fit in CNT_W bits (CNT_W >= 2 for PORT waits)");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               nas_d;
  logic [CNT_W-1:0]   waits;

  c1_wait_sel #(
    .CNT_W      (CNT_W),
    .CARD_WAITS (CARD_WAITS),
    .ROM_WAITS  (ROM_WAITS)
  ) u_wait_sel (
    .nROM_ZONE  (bus.nROM_ZONE),
    .nPORT_ZONE (bus.nPORT_ZONE),
    .nCARD_ZONE (bus.nCARD_ZONE),
    .nROMWAIT   (bus.nROMWAIT),
    .nPWAIT0    (bus.nPWAIT0),
    .nPWAIT1    (bus.nPWAIT1),
    .PDTACK     (bus.PDTACK),
    .waits      (waits)
  );

  // nAS high on any edge aborts or completes the cycle; start needs nAS low after a high sample.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      nas_d <= 1'b1;
    end else begin
      nas_d <= bus.nAS;
      if (bus.nAS) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (nas_d) begin
              if (waits == '0) begin
                state <= ST_ACK;
              end else begin
                state <= ST_WAIT;
                cnt   <= waits - CNT_W'(1);
              end
            end
          end
          ST_WAIT: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= ST_ACK;
            end
          end
          ST_ACK:  state <= ST_ACK;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Gating with the live nAS releases DTACK in the same delta that the CPU ends the cycle.
  assign bus.nDTACK = ~(state == ST_ACK) | bus.nAS;
  assign bus.BUSY   = (state == ST_WAIT);

`ifdef C1_WAIT_STATS_EN
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      WAIT_TOTAL <= 16'd0;
    end else if (state == ST_WAIT && WAIT_TOTAL != 16'hFFFF) begin
      WAIT_TOTAL <= WAIT_TOTAL + 16'd1;
    end
  end
`endif

endmodule
